// File: rtl/arbitro_clasificacion_if.sv
// Bus between the word source, the VC FIFOs and the routing arbiter on one side
// and arbitro_clasificacion on the other.
interface arbitro_clasificacion_if #(
  parameter int WIDTH = 6,
  parameter int CNT_W = 4
) ();
  logic [WIDTH-1:0] data_in;
  logic             data_in_valid;
  logic             VC0_pop;
  logic             VC1_pop;
  logic             VC0_push;
  logic             VC1_push;
  logic [WIDTH-1:0] VC0_data;
  logic [WIDTH-1:0] VC1_data;
  logic             in_pause;
  logic [CNT_W-1:0] VC0_count;
  logic [CNT_W-1:0] VC1_count;

  // Classifier side
  modport slave (
    input  data_in, data_in_valid, VC0_pop, VC1_pop,
    output VC0_push, VC1_push, VC0_data, VC1_data, in_pause, VC0_count, VC1_count
  );

  // Source / FIFO / routing-arbiter side
  modport master (
    output data_in, data_in_valid, VC0_pop, VC1_pop,
    input  VC0_push, VC1_push, VC0_data, VC1_data, in_pause, VC0_count, VC1_count
  );
endinterface

// File: rtl/arbitro_clasificacion.sv
// arbitro_clasificacion: ingress classifier for the VC path. Splits the word
// stream into VC0/VC1 by CLASS_BIT, tracks both FIFO occupancies and raises
// in_pause. A one-entry skid register K absorbs the word in flight when the
// stage register S stalls on a full target FIFO.
// Optional feature: define ARB_DROP_CNT_EN to add the saturating drop_count port.
module arbitro_clasificacion #(
  parameter int WIDTH     = 6,
  parameter int CLASS_BIT = 4,
  parameter int DEPTH     = 8,
  parameter int CNT_W     = 4,
  parameter int AF_VC0    = 6,
  parameter int AF_VC1    = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  arbitro_clasificacion_if.slave  bus
`ifdef ARB_DROP_CNT_EN
  ,
  output logic [7:0]              drop_count
`endif
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF0_C   = CNT_W'(AF_VC0);
  localparam logic [CNT_W-1:0] AF1_C   = CNT_W'(AF_VC1);

  logic             s_valid, k_valid;
  logic [WIDTH-1:0] s_word, k_word;
  logic [WIDTH-1:0] last0, last1;
  logic [CNT_W-1:0] cnt0, cnt1, cnt0_n, cnt1_n;
  logic             push0, push1, s_free, k_valid_n, drop;
  logic             pause_q;

  // Push decision from S and the registered counts only
  always_comb begin
    push0 = 1'b0;
    push1 = 1'b0;
    if (s_valid) begin
      if (s_word[CLASS_BIT]) push1 = (cnt1 < DEPTH_C);
      else                   push0 = (cnt0 < DEPTH_C);
    end
    s_free = !s_valid || push0 || push1;
    drop   = !s_free && bus.data_in_valid && k_valid;
    if (s_free) k_valid_n = k_valid ? bus.data_in_valid : 1'b0;
    else        k_valid_n = k_valid || bus.data_in_valid;
  end

  // Next occupancy; a pop against an empty FIFO is ignored
  always_comb begin
    cnt0_n = cnt0;
    cnt1_n = cnt1;
    if (push0 && !(bus.VC0_pop && cnt0 != '0)) cnt0_n = cnt0 + 1'b1;
    else if (!push0 && bus.VC0_pop && cnt0 != '0) cnt0_n = cnt0 - 1'b1;
    if (push1 && !(bus.VC1_pop && cnt1 != '0)) cnt1_n = cnt1 + 1'b1;
    else if (!push1 && bus.VC1_pop && cnt1 != '0) cnt1_n = cnt1 - 1'b1;
  end

  // Stage/skid pipeline: K always drains into S before new input is taken
  always_ff @(posedge clk) begin
    if (reset) begin
      s_valid <= 1'b0;
      s_word  <= '0;
      k_valid <= 1'b0;
      k_word  <= '0;
    end else if (s_free) begin
      if (k_valid) begin
        s_valid <= 1'b1;
        s_word  <= k_word;
        k_valid <= bus.data_in_valid;
        k_word  <= bus.data_in;
      end else begin
        s_valid <= bus.data_in_valid;
        s_word  <= bus.data_in;
      end
    end else if (bus.data_in_valid && !k_valid) begin
      k_valid <= 1'b1;
      k_word  <= bus.data_in;
    end
  end

  // Counters, held output data and registered back-pressure
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt0    <= '0;
      cnt1    <= '0;
      last0   <= '0;
      last1   <= '0;
      pause_q <= 1'b0;
    end else begin
      cnt0    <= cnt0_n;
      cnt1    <= cnt1_n;
      if (push0) last0 <= s_word;
      if (push1) last1 <= s_word;
      pause_q <= (cnt0_n >= AF0_C) || (cnt1_n >= AF1_C) || k_valid_n;
    end
  end

`ifdef ARB_DROP_CNT_EN
  // Saturating count of words lost with S stalled and K occupied
  always_ff @(posedge clk) begin
    if (reset)                      drop_count <= '0;
    else if (drop && drop_count != '1) drop_count <= drop_count + 8'd1;
  end
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

  assign bus.VC0_push  = push0;
  assign bus.VC1_push  = push1;
  assign bus.VC0_data  = push0 ? s_word : last0;
  assign bus.VC1_data  = push1 ? s_word : last1;
  assign bus.VC0_count = cnt0;
  assign bus.VC1_count = cnt1;
  assign bus.in_pause  = pause_q;

endmodule

// File: tb/tb_arbitro_clasificacion.sv
// Directed bench for arbitro_clasificacion with hand-computed expectations.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_arbitro_clasificacion;

  logic clk = 1'b0;
  logic reset;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  arbitro_clasificacion_if #(.WIDTH(6), .CNT_W(4)) bus ();

`ifdef ARB_DROP_CNT_EN
  logic [7:0] drop_count;
`endif

  arbitro_clasificacion #(
    .WIDTH(6), .CLASS_BIT(4), .DEPTH(8), .CNT_W(4), .AF_VC0(6), .AF_VC1(6)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
`ifdef ARB_DROP_CNT_EN
    ,
    .drop_count (drop_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. reset with valid input present
    reset = 1'b1;
    bus.data_in = 6'h15; bus.data_in_valid = 1'b1;
    bus.VC0_pop = 1'b0;  bus.VC1_pop = 1'b0;
    tick(); tick(); tick();
    chk("rst_push0", int'(bus.VC0_push), 0);
    chk("rst_push1", int'(bus.VC1_push), 0);
    chk("rst_data0", int'(bus.VC0_data), 0);
    chk("rst_data1", int'(bus.VC1_data), 0);
    chk("rst_pause", int'(bus.in_pause), 0);
    chk("rst_cnt1",  int'(bus.VC1_count), 0);
    reset = 1'b0; bus.data_in_valid = 1'b0;
    tick();
    chk("rel_cnt0",  int'(bus.VC0_count), 0);
    chk("rel_pause", int'(bus.in_pause), 0);

    // 2. classification and 1-cycle latency
    bus.data_in = 6'h05; bus.data_in_valid = 1'b1;
    tick();
    bus.data_in = 6'h15;
    chk("cls_push0", int'(bus.VC0_push), 1);
    chk("cls_data0", int'(bus.VC0_data), 'h05);
    chk("cls_nopush1", int'(bus.VC1_push), 0);
    tick();
    bus.data_in_valid = 1'b0;
    chk("cls_push1", int'(bus.VC1_push), 1);
    chk("cls_data1", int'(bus.VC1_data), 'h15);
    chk("cls_nopush0", int'(bus.VC0_push), 0);
    chk("cls_hold0", int'(bus.VC0_data), 'h05);
    tick();
    chk("cls_idle1", int'(bus.VC1_push), 0);
    chk("cls_hold1", int'(bus.VC1_data), 'h15);
    chk("cls_cnt0", int'(bus.VC0_count), 1);
    chk("cls_cnt1", int'(bus.VC1_count), 1);
    bus.VC0_pop = 1'b1; bus.VC1_pop = 1'b1;
    tick();
    bus.VC0_pop = 1'b0; bus.VC1_pop = 1'b0;
    chk("clr_cnt0", int'(bus.VC0_count), 0);
    chk("clr_cnt1", int'(bus.VC1_count), 0);

    // 3. almost-full threshold on VC0
    for (int i = 0; i < 6; i++) begin
      bus.data_in = 6'(i); bus.data_in_valid = 1'b1;
      tick();
    end
    bus.data_in_valid = 1'b0;
    chk("af_cnt5", int'(bus.VC0_count), 5);
    chk("af_pause5", int'(bus.in_pause), 0);
    tick();
    chk("af_cnt6", int'(bus.VC0_count), 6);
    chk("af_pause6", int'(bus.in_pause), 1);
    bus.VC0_pop = 1'b1;
    tick(); tick(); tick();
    bus.VC0_pop = 1'b0;
    chk("af_cnt3", int'(bus.VC0_count), 3);
    chk("af_pause3", int'(bus.in_pause), 0);

    // 5. push+pop at count 4, pop at count 0
    bus.data_in = 6'h01; bus.data_in_valid = 1'b1;
    tick();
    bus.data_in_valid = 1'b0;
    tick();
    chk("pp_cnt4a", int'(bus.VC0_count), 4);
    bus.data_in = 6'h02; bus.data_in_valid = 1'b1;
    tick();
    bus.data_in_valid = 1'b0; bus.VC0_pop = 1'b1;
    chk("pp_push", int'(bus.VC0_push), 1);
    tick();
    chk("pp_cnt4b", int'(bus.VC0_count), 4);
    tick(); tick(); tick(); tick();
    chk("pp_cnt0", int'(bus.VC0_count), 0);
    tick();
    bus.VC0_pop = 1'b0;
    chk("pp_underflow", int'(bus.VC0_count), 0);

    // 4. VC1 full: S stalls, K holds the next word, release in order
    for (int i = 0; i < 10; i++) begin
      bus.data_in = 6'(8'h10 + i); bus.data_in_valid = 1'b1;
      tick();
    end
    bus.data_in_valid = 1'b0;
    chk("full_cnt8", int'(bus.VC1_count), 8);
    chk("full_nopush", int'(bus.VC1_push), 0);
    chk("full_pause", int'(bus.in_pause), 1);
    tick();
    chk("stall_nopush", int'(bus.VC1_push), 0);
    chk("stall_cnt8", int'(bus.VC1_count), 8);
    bus.VC1_pop = 1'b1;
    tick();
    chk("rel_push_a", int'(bus.VC1_push), 1);
    chk("rel_data_a", int'(bus.VC1_data), 'h18);
    chk("rel_cnt7a", int'(bus.VC1_count), 7);
    tick();
    bus.VC1_pop = 1'b0;
    chk("rel_push_b", int'(bus.VC1_push), 1);
    chk("rel_data_b", int'(bus.VC1_data), 'h19);
    chk("rel_cnt7b", int'(bus.VC1_count), 7);
    tick();
    chk("rel_done", int'(bus.VC1_push), 0);
    chk("rel_cnt8", int'(bus.VC1_count), 8);
    bus.VC1_pop = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    bus.VC1_pop = 1'b0;
    chk("drain_cnt0", int'(bus.VC1_count), 0);
    chk("drain_pause", int'(bus.in_pause), 0);

    // 6. drops with S stalled and K full, then reset mid-stall
    for (int i = 0; i < 13; i++) begin
      bus.data_in = 6'(8'h20 + i); bus.data_in_valid = 1'b1;
      tick();
    end
    chk("drop_cnt8", int'(bus.VC0_count), 8);
    chk("drop_nopush", int'(bus.VC0_push), 0);
`ifdef ARB_DROP_CNT_EN
    chk("drop_count3", int'(drop_count), 3);
`endif
    reset = 1'b1;
    tick();
    chk("mrst_push0", int'(bus.VC0_push), 0);
    chk("mrst_cnt0", int'(bus.VC0_count), 0);
    chk("mrst_pause", int'(bus.in_pause), 0);
`ifdef ARB_DROP_CNT_EN
    chk("mrst_drop", int'(drop_count), 0);
`endif
    reset = 1'b0; bus.data_in_valid = 1'b0;
    tick();
    chk("post_push0", int'(bus.VC0_push), 0);
    chk("post_push1", int'(bus.VC1_push), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
